// File: rtl/queue_to_sb_fifo_sim.sv
// Receive endpoint for a switchboard-style packet queue: polls the queue into a
// DEPTH-entry FIFO and presents the head packet as a valid/ready stream.
module queue_to_sb_fifo_sim #(
    parameter int DW                 = 416,
    parameter int DEPTH              = 4,
    parameter bit VALID_MODE_DEFAULT = 1'b0,
    parameter int QDEPTH             = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [DW-1:0]              data,
    output logic [31:0]                dest,
    output logic                       last,
    output logic                       valid,
    input  logic                       ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int QW = $clog2(QDEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [QW:0]   Q_FULL   = (QW+1)'(QDEPTH);

    // Channel state owned by the software side of the queue; reset never touches it.
    int            id         = -1;
    logic          valid_mode = VALID_MODE_DEFAULT;
    logic [QW:0]   q_tail     = '0;
    logic [DW-1:0] q_data [QDEPTH];
    logic [31:0]   q_dest [QDEPTH];
    logic          q_last [QDEPTH];

    logic [QW:0]   q_head_q;
    logic [DW-1:0] mem_data_q [DEPTH];
    logic [31:0]   mem_dest_q [DEPTH];
    logic          mem_last_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          gate_q, gate_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          push, pop;

    task automatic init(input string uri);
        if (id == -1 && uri.len() != 0) begin
            q_tail = '0;
            id     = 0;
        end
    endtask

    task automatic set_valid_mode(input logic v);
        valid_mode = v;
    endtask

    // Producer side of the shared queue; ok=0 means the queue is full or not open.
    task automatic sb_send(input logic [DW-1:0] d, input logic [31:0] de,
                           input logic l, output logic ok);
        ok = (id != -1) && ((q_tail - q_head_q) != Q_FULL);
        if (ok) begin
            q_data[q_tail[QW-1:0]] = d;
            q_dest[q_tail[QW-1:0]] = de;
            q_last[q_tail[QW-1:0]] = l;
            q_tail = q_tail + (QW+1)'(1);
        end
    endtask

    assign valid = (count_q != '0) && gate_q;
    assign data  = mem_data_q[rd_ptr_q];
    assign dest  = mem_dest_q[rd_ptr_q];
    assign last  = mem_last_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        pop      = valid && ready;
        // Polling uses the pre-edge occupancy, so a full FIFO never polls even while popping.
        push     = !reset && (id != -1) && (count_q != FULL_CNT) && (q_tail != q_head_q);
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (!valid_mode) begin
            gate_d = 1'b1;
        end else if (valid && !ready) begin
            gate_d = 1'b1;
        end else begin
            gate_d = lfsr_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            gate_q   <= 1'b0;
            lfsr_q   <= 16'hACE1;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            gate_q   <= gate_d;
            lfsr_q   <= lfsr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= q_data[q_head_q[QW-1:0]];
            mem_dest_q[wr_ptr_q] <= q_dest[q_head_q[QW-1:0]];
            mem_last_q[wr_ptr_q] <= q_last[q_head_q[QW-1:0]];
        end
    end

    // The queue read index stays parked at zero until the channel is opened.
    always_ff @(posedge clk) begin
        if (id == -1) begin
            q_head_q <= '0;
        end else if (push) begin
            q_head_q <= q_head_q + (QW+1)'(1);
        end
    end
endmodule

// File: tb/tb_queue_to_sb_fifo_sim.sv
// Bench for queue_to_sb_fifo_sim: queue-level packet model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_queue_to_sb_fifo_sim;
    localparam int DW    = 416;
    localparam int DEPTH = 4;
    localparam int QD    = 16;
    localparam int PKW   = DW + 33;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          ready = 1'b0;
    logic [DW-1:0] data;
    logic [31:0]   dest;
    logic          last;
    logic          valid;
    logic [2:0]    count;

    queue_to_sb_fifo_sim #(
        .DW(DW), .DEPTH(DEPTH), .VALID_MODE_DEFAULT(1'b0), .QDEPTH(QD)
    ) dut (
        .clk(clk), .reset(reset), .data(data), .dest(dest), .last(last),
        .valid(valid), .ready(ready), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Packets are {last, dest, data}; sq mirrors the shared queue, fifo_m the buffered packets.
    logic [PKW-1:0] sq[$];
    logic [PKW-1:0] fifo_m[$];
    logic [PKW-1:0] got_q[$];
    int             got_cyc[$];
    bit             m_open  = 1'b0;
    bit             m_mode  = 1'b0;
    bit             m_gate  = 1'b0;
    bit             m_known = 1'b1;
    bit             m_hold  = 1'b0;
    bit             chk_en  = 1'b0;
    logic           obs_valid = 1'b0;
    logic [PKW-1:0] obs_pkt   = '0;
    int             cyc = 0;
    int             delivered = 0;
    int             seq = 100;

    function automatic void chk(input string nm, input logic [PKW-1:0] act, input logic [PKW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] mk_data(input int s);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        d[31:0] = 32'(s);
        return d;
    endfunction

    // Model: at each edge, pop the head if it was offered and accepted, then poll one packet.
    always @(posedge clk) begin
        bit v, pp, pu;
        cyc++;
        if (reset) begin
            fifo_m.delete();
            m_gate  = 1'b0;
            m_known = 1'b1;
            m_hold  = 1'b0;
        end else if (chk_en) begin
            v  = m_known ? (fifo_m.size() != 0 && m_gate) : (obs_valid && fifo_m.size() != 0);
            pp = v && ready;
            pu = m_open && (fifo_m.size() < DEPTH) && (sq.size() != 0);
            if (pp) begin
                void'(fifo_m.pop_front());
                delivered++;
                got_q.push_back(obs_pkt);
                got_cyc.push_back(cyc);
            end
            if (pu) fifo_m.push_back(sq.pop_front());
            m_hold = v && !ready;
            if (m_mode == 1'b0) begin
                m_gate  = 1'b1;
                m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        obs_valid = valid;
        obs_pkt   = {last, dest, data};
        if (chk_en) begin
            chk("count", PKW'(count), PKW'(fifo_m.size()));
            if (m_known) begin
                chk("valid", PKW'(valid), PKW'(fifo_m.size() != 0 && m_gate));
            end else begin
                if (fifo_m.size() == 0) chk("valid_empty", PKW'(valid), '0);
                if (m_hold) chk("valid_hold", PKW'(valid), PKW'(1));
            end
            if (valid && fifo_m.size() != 0) chk("head", {last, dest, data}, fifo_m[0]);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [31:0] de, input logic l, output bit ok);
        logic dut_ok;
        bit   exp_ok;
        exp_ok = m_open && (sq.size() < QD);
        dut.sb_send(d, de, l, dut_ok);
        chk("send_ok", PKW'(dut_ok), PKW'(exp_ok));
        ok = exp_ok;
        if (exp_ok) sq.push_back({l, de, d});
    endtask

    task automatic set_mode(input bit v);
        dut.set_valid_mode(v);
        m_mode = v;
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = budget;
        while ((sq.size() != 0 || fifo_m.size() != 0) && b > 0) begin
            tick();
            b--;
        end
        chk("drain_in_time", PKW'(b > 0), PKW'(1));
        chk("drain_count", PKW'(count), '0);
    endtask

    task automatic run_stream(input int n, input bit rnd_ready, input int sw1, input int sw0);
        int del0, sent, budget, c0, d0;
        bit did1, did0, ok;
        del0 = delivered; sent = 0; budget = 20 * n + 200;
        did1 = 1'b0; did0 = 1'b0; c0 = 0; d0 = 0;
        while ((delivered - del0) < n && budget > 0) begin
            if (sw1 >= 0 && !did1 && (delivered - del0) >= sw1) begin
                set_mode(1'b1);
                did1 = 1'b1;
            end
            if (sw0 >= 0 && !did0 && (delivered - del0) >= sw0) begin
                set_mode(1'b0);
                did0 = 1'b1;
                c0   = cyc;
                d0   = delivered - del0;
            end
            ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < n && sq.size() < QD) begin
                send(mk_data(seq), 32'(seq), seq[0], ok);
                seq++;
                sent++;
            end
            tick();
            budget--;
        end
        chk("stream_done", PKW'(delivered - del0), PKW'(n));
        if (did0) chk("mode0_back_to_back", PKW'((cyc - c0) <= (n - d0) + 4), PKW'(1));
        ready = 1'b1;
    endtask

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bit             ok;
        int             d0;
        logic [PKW-1:0] first_pkt;
        logic [PKW-1:0] exp_pkt;
        logic [PKW-1:0] t5_pkts[$];

        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_count", PKW'(count), '0);
        chk("reset_valid", PKW'(valid), '0);
        reset = 1'b0;

        // Channel never opened: nothing is accepted or delivered.
        ready = 1'b1;
        send(DW'(7), 32'h10, 1'b1, ok);
        for (int i = 0; i < 100; i++) tick();
        chk("t1_count", PKW'(count), '0);
        chk("t1_valid", PKW'(valid), '0);

        // Three packets, mode 0, ready high: one-clock latency then back-to-back beats.
        dut.init("sb_rx.q");
        m_open = 1'b1;
        tick();
        got_q.delete();
        got_cyc.delete();
        for (int i = 1; i <= 3; i++) send(DW'(i), 32'h10, 1'b1, ok);
        tick();
        chk("t2_latency_valid", PKW'(valid), PKW'(1));
        chk("t2_latency_data", PKW'(data), PKW'(1));
        wait_drain(50);
        chk("t2_beats", PKW'(got_q.size()), PKW'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size()) begin
                exp_pkt = {1'b1, 32'h10, DW'(i + 1)};
                chk("t2_beat", got_q[i], exp_pkt);
                if (i > 0) chk("t2_consecutive", PKW'(got_cyc[i] - got_cyc[i-1]), PKW'(1));
            end
        end

        // Backpressure: FIFO saturates at DEPTH, head held on the first packet.
        ready = 1'b0;
        first_pkt = '0;
        for (int i = 0; i < 10; i++) begin
            exp_pkt = {seq[0], 32'(seq), mk_data(seq)};
            if (i == 0) first_pkt = exp_pkt;
            send(exp_pkt[DW-1:0], exp_pkt[DW+31:DW], exp_pkt[PKW-1], ok);
            seq++;
            tick();
        end
        for (int i = 0; i < 4; i++) tick();
        chk("t3_count_full", PKW'(count), PKW'(4));
        chk("t3_valid_held", PKW'(valid), PKW'(1));
        chk("t3_head_first", {last, dest, data}, first_pkt);
        d0 = delivered;
        ready = 1'b1;
        wait_drain(100);
        chk("t3_all_delivered", PKW'(delivered - d0), PKW'(10));

        // Random valid gating with random ready.
        set_mode(1'b1);
        run_stream(1000, 1'b1, -1, -1);
        set_mode(1'b0);
        wait_drain(50);

        // Reset with three packets buffered.
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(mk_data(seq), 32'(seq), seq[0], ok);
            seq++;
        end
        for (int i = 0; i < 5; i++) tick();
        chk("t5_count_before", PKW'(count), PKW'(3));
        reset = 1'b1;
        tick();
        chk("t5_count_after", PKW'(count), '0);
        chk("t5_valid_after", PKW'(valid), '0);
        reset = 1'b0;
        ready = 1'b1;
        d0 = delivered;
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_pkt = {1'b0, 32'h55, DW'(500 + i)};
            t5_pkts.push_back(exp_pkt);
            send(exp_pkt[DW-1:0], 32'h55, 1'b0, ok);
        end
        wait_drain(50);
        chk("t5_delivered", PKW'(delivered - d0), PKW'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size()) chk("t5_order", got_q[i], t5_pkts[i]);
        end

        // Mode switches mid-stream.
        run_stream(200, 1'b0, 50, 100);
        wait_drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
